// File: rtl/fma16_issue.sv
// Issue/capture stage in front of the combinational fma16 datapath: commands are queued,
// held on the fma16 inputs for FMA_LAT cycles, then the result is registered for the consumer.
module fma16_issue #(
  parameter int DEPTH   = 4,
  parameter int FMA_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_x,
  input  logic [15:0]              in_y,
  input  logic [15:0]              in_z,
  input  logic                     in_mul,
  input  logic                     in_add,
  input  logic                     in_negr,
  input  logic                     in_negz,
  input  logic [1:0]               in_roundmode,
  output logic [15:0]              fma_x,
  output logic [15:0]              fma_y,
  output logic [15:0]              fma_z,
  output logic                     fma_mul,
  output logic                     fma_add,
  output logic                     fma_negr,
  output logic                     fma_negz,
  output logic [1:0]               fma_roundmode,
  input  logic [15:0]              fma_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FMA_LAT + 1);
  localparam logic [AW:0]   C_FULL   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_SETTLE = CW'(FMA_LAT - 1);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negr;
    logic        negz;
    logic [1:0]  rm;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  cmd_t          r_mem [DEPTH];
  cmd_t          r_cmd;
  cmd_t          w_in_cmd;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_settle;
  logic [15:0]   r_result;
  logic          r_out_valid;
  state_t        r_state, w_next;
  logic          w_push, w_pop, w_capture, w_nonempty;

  assign w_in_cmd   = {in_x, in_y, in_z, in_mul, in_add, in_negr, in_negz, in_roundmode};
  assign in_ready   = (r_count < C_FULL);
  assign w_push     = in_valid & in_ready;
  assign w_nonempty = (r_count != '0);

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in_cmd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_nonempty) begin
        w_pop  = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: if (r_settle == '0) begin
        w_capture = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: if (out_ready) begin
        w_pop  = w_nonempty;
        w_next = w_nonempty ? S_EXEC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_cmd       <= '0;
      r_settle    <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      // fma_* keep the last issued command until the next pop.
      if (w_pop) begin
        r_cmd    <= r_mem[r_rptr];
        r_settle <= C_SETTLE;
      end else if (r_state == S_EXEC && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end

      if (w_capture) begin
        r_result    <= fma_result;
        r_out_valid <= 1'b1;
      end else if (r_state == S_DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fma_x         = r_cmd.x;
  assign fma_y         = r_cmd.y;
  assign fma_z         = r_cmd.z;
  assign fma_mul       = r_cmd.mul;
  assign fma_add       = r_cmd.add;
  assign fma_negr      = r_cmd.negr;
  assign fma_negz      = r_cmd.negz;
  assign fma_roundmode = r_cmd.rm;
  assign out_valid     = r_out_valid;
  assign out_result    = r_result;
  assign busy          = (r_state != S_IDLE);
  assign count         = r_count;

endmodule
